// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes one BCD-to-7-segment decoder across four
// common-anode digits. A 4-digit BCD value is snapshotted at each frame start
// and digits are scanned 0 -> 3, each slot opening with an all-dark dead time
// to prevent ghosting. Leading zeros (optional) and non-BCD codes are blanked.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_enable     1 = scan, 0 = dark and scanner held in idle
//   i_digits     BCD digits, [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   i_dp_en      per-digit decimal point request
//   i_blank_lz   suppress leading zeros on digits 3..1
//   o_bcd_out    code for the decoder (0 when the digit is blanked)
//   o_an         active-low anode enables, bit i = digit i
//   o_dp         active-low decimal point
//   o_digit_sel  index of the current slot
//   o_frame_tick one-cycle pulse on the first cycle of each frame
module seg_scan_ctrl #(
  parameter int unsigned SLOT_CYCLES = 100000,
  parameter int unsigned DEAD_CYCLES = 2000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp_en,
  input  logic        i_blank_lz,
  output logic [3:0]  o_bcd_out,
  output logic [3:0]  o_an,
  output logic        o_dp,
  output logic [1:0]  o_digit_sel,
  output logic        o_frame_tick
);

  localparam int unsigned CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);
  localparam logic [CntW-1:0] SlotLast = CntW'(SLOT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDead, StDrive} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_sel;
  logic [15:0]     r_snap;
  logic [3:0]      r_dp_en;
  logic [3:0]      r_blank;

  logic [3:0] w_blank_new;
  logic [1:0] w_sel_nxt;
  logic [3:0] w_bcd_first;
  logic [3:0] w_bcd_next;

  // Digit i is blanked when its code is not BCD, or (with suppression on) when
  // it and every higher digit are zero. Digit 0 is never blanked for zero.
  function automatic logic [3:0] blank_mask(input logic [15:0] d, input logic lz);
    logic [3:0] m;
    logic       zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      zero_above = zero_above && (d[4*i +: 4] == 4'd0);
      m[i]       = (d[4*i +: 4] > 4'd9) || (lz && (i >= 1) && zero_above);
    end
    return m;
  endfunction

  assign w_blank_new = blank_mask(i_digits, i_blank_lz);
  assign w_sel_nxt   = r_sel + 2'd1;
  // Code for digit 0 of a frame that is starting now comes straight from the inputs.
  assign w_bcd_first = w_blank_new[0] ? 4'd0 : i_digits[3:0];
  assign w_bcd_next  = r_blank[w_sel_nxt] ? 4'd0 : r_snap[{w_sel_nxt, 2'b00} +: 4];

  assign o_digit_sel = r_sel;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_snap       <= '0;
      r_dp_en      <= '0;
      r_blank      <= '0;
      o_bcd_out    <= 4'd0;
      o_an         <= 4'hF;
      o_dp         <= 1'b1;
      o_frame_tick <= 1'b0;
    end else if (!i_enable) begin
      // Abort any slot in progress; the next enable restarts a full frame.
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      o_bcd_out    <= 4'd0;
      o_an         <= 4'hF;
      o_dp         <= 1'b1;
      o_frame_tick <= 1'b0;
    end else begin
      o_frame_tick <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_state      <= StDead;
          r_cnt        <= '0;
          r_sel        <= 2'd0;
          r_snap       <= i_digits;
          r_dp_en      <= i_dp_en;
          r_blank      <= w_blank_new;
          o_bcd_out    <= w_bcd_first;
          o_frame_tick <= 1'b1;
          o_an         <= 4'hF;
          o_dp         <= 1'b1;
        end
        StDead: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == DeadLast) begin
            r_state <= StDrive;
            o_an    <= r_blank[r_sel] ? 4'hF : ~(4'b0001 << r_sel);
            o_dp    <= r_blank[r_sel] | ~r_dp_en[r_sel];
          end
        end
        StDrive: begin
          if (r_cnt == SlotLast) begin
            r_state <= StDead;
            r_cnt   <= '0;
            r_sel   <= w_sel_nxt;
            o_an    <= 4'hF;
            o_dp    <= 1'b1;
            if (r_sel == 2'd3) begin
              // Wrap to digit 0: new frame, new snapshot.
              r_snap       <= i_digits;
              r_dp_en      <= i_dp_en;
              r_blank      <= w_blank_new;
              o_bcd_out    <= w_bcd_first;
              o_frame_tick <= 1'b1;
            end else begin
              o_bcd_out <= w_bcd_next;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int SLOT = 8;
  localparam int DEAD = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] obs;
  assign obs = {an, bcd_out, dp, frame_tick, digit_sel};

  seg_scan_ctrl #(
    .SLOT_CYCLES(SLOT),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_digits    (digits),
    .i_dp_en     (dp_en),
    .i_blank_lz  (blank_lz),
    .o_bcd_out   (bcd_out),
    .o_an        (an),
    .o_dp        (dp),
    .o_digit_sel (digit_sel),
    .o_frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an, bcd, dp, tick, sel} at cycle c of a scan (c=0 is the frame_tick
  // cycle), from a hand-written per-digit table: lit digits, shown codes, dp requests.
  function automatic logic [11:0] exp_vec(input int c, input logic [3:0] lit,
                                          input logic [15:0] bcds, input logic [3:0] dps);
    int         slot;
    int         ph;
    logic [3:0] e_an;
    logic       e_dp;
    slot = (c / SLOT) % 4;
    ph   = c % SLOT;
    e_an = 4'hF;
    e_dp = 1'b1;
    if (ph >= DEAD && lit[slot]) begin
      e_an = ~(4'b0001 << slot);
      e_dp = ~dps[slot];
    end
    return {e_an, bcds[4*slot +: 4], e_dp, (ph == 0 && slot == 0), slot[1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Park in idle, load inputs, enable; returns at the sample point of cycle 0.
  task automatic start_scan(input logic [15:0] d, input logic [3:0] dpe, input logic lz);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    digits   = d;
    dp_en    = dpe;
    blank_lz = lz;
    enable   = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable   = 1'b1;
    digits   = 16'h1234;
    dp_en    = 4'b0100;
    blank_lz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if ({an, dp, bcd_out, frame_tick} !== {4'hF, 1'b1, 4'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset k=%0d got an=%b dp=%b bcd=%h tick=%b exp an=1111 dp=1 bcd=0 tick=0",
                 k, an, dp, bcd_out, frame_tick);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First anode low exactly DEAD+1 cycles after release.
    for (int c = 0; c <= DEAD; c++) begin
      step();
      n_tests++;
      if (obs !== exp_vec(c, 4'b1111, 16'h1234, 4'b0100)) begin
        n_fail++;
        $display("FAIL reset_release c=%0d got=%h exp=%h", c, obs,
                 exp_vec(c, 4'b1111, 16'h1234, 4'b0100));
      end
    end
  endtask

  task automatic test_basic_scan();
    start_scan(16'h1234, 4'b0100, 1'b0);
    for (int c = 0; c < 2 * FRAME; c++) begin
      n_tests++;
      if (obs !== exp_vec(c, 4'b1111, 16'h1234, 4'b0100)) begin
        n_fail++;
        $display("FAIL basic c=%0d got=%h exp=%h", c, obs, exp_vec(c, 4'b1111, 16'h1234, 4'b0100));
      end
      step();
    end
  endtask

  task automatic test_leading_zeros();
    logic [15:0] d_t   [3] = '{16'h0005, 16'h0005, 16'h0000};
    logic        lz_t  [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0]  dpe_t [3] = '{4'b1111, 4'b0000, 4'b0000};
    logic [3:0]  lit_t [3] = '{4'b0001, 4'b1111, 4'b0001};
    logic [15:0] bcd_t [3] = '{16'h0005, 16'h0005, 16'h0000};
    for (int v = 0; v < 3; v++) begin
      start_scan(d_t[v], dpe_t[v], lz_t[v]);
      for (int c = 0; c < FRAME + 1; c++) begin
        n_tests++;
        if (obs !== exp_vec(c, lit_t[v], bcd_t[v], dpe_t[v])) begin
          n_fail++;
          $display("FAIL leading_zeros v=%0d c=%0d got=%h exp=%h", v, c, obs,
                   exp_vec(c, lit_t[v], bcd_t[v], dpe_t[v]));
        end
        step();
      end
    end
  endtask

  task automatic test_invalid_interior();
    // Digit 1 (A) blanked with code 0 and no dp; interior zero on digit 2 shown.
    start_scan(16'h30A0, 4'b0010, 1'b1);
    for (int c = 0; c < FRAME + 1; c++) begin
      n_tests++;
      if (obs !== exp_vec(c, 4'b1101, 16'h3000, 4'b0010)) begin
        n_fail++;
        $display("FAIL invalid_interior c=%0d got=%h exp=%h", c, obs,
                 exp_vec(c, 4'b1101, 16'h3000, 4'b0010));
      end
      step();
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] shown;
    start_scan(16'h1234, 4'b0000, 1'b0);
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c == SLOT + 3) digits = 16'h5678;
      shown = (c < FRAME) ? 16'h1234 : 16'h5678;
      n_tests++;
      if (obs !== exp_vec(c, 4'b1111, shown, 4'b0000)) begin
        n_fail++;
        $display("FAIL snapshot c=%0d got=%h exp=%h", c, obs, exp_vec(c, 4'b1111, shown, 4'b0000));
      end
      step();
    end
  endtask

  task automatic test_enable_drop();
    start_scan(16'h1234, 4'b0100, 1'b0);
    for (int c = 0; c <= 2 * SLOT + 4; c++) begin
      n_tests++;
      if (obs !== exp_vec(c, 4'b1111, 16'h1234, 4'b0100)) begin
        n_fail++;
        $display("FAIL drop_pre c=%0d got=%h exp=%h", c, obs, exp_vec(c, 4'b1111, 16'h1234, 4'b0100));
      end
      if (c < 2 * SLOT + 4) step();
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if ({an, dp, frame_tick, digit_sel} !== {4'hF, 1'b1, 1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL drop_dark k=%0d got an=%b dp=%b tick=%b sel=%0d exp an=1111 dp=1 tick=0 sel=0",
                 k, an, dp, frame_tick, digit_sel);
      end
    end
    enable = 1'b1;
    step();
    for (int c = 0; c < 2 * SLOT; c++) begin
      n_tests++;
      if (obs !== exp_vec(c, 4'b1111, 16'h1234, 4'b0100)) begin
        n_fail++;
        $display("FAIL drop_restart c=%0d got=%h exp=%h", c, obs,
                 exp_vec(c, 4'b1111, 16'h1234, 4'b0100));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_leading_zeros();
    test_invalid_interior();
    test_snapshot();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller that shares the single BCD-to-7-segment decoder of the stopwatch across four common-anode digits. It snapshots a 4-digit BCD value at each frame start and scans digits 0→3. It drives the decoder input, the active-low anodes and the decimal point, inserting a dead-time blank between digits to prevent ghosting. It also applies leading-zero suppression and blanks non-BCD codes.

## Interface
- SLOT_CYCLES, 100000, clock cycles per digit slot (≥ DEAD_CYCLES+1); 100000 at 100 MHz gives a 250 Hz frame rate.
- DEAD_CYCLES, 2000, cycles at the start of each slot with all anodes off (≥1).
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- enable  input  1  1 = scan; 0 = display dark, scanner held
- digits  input  16  BCD digits; [3:0] = digit 0 (rightmost) … [15:12] = digit 3
- dp_en  input  4  per-digit decimal point request, bit i = digit i
- blank_lz  input  1  1 = suppress leading zeros on digits 3..1
- bcd_out  output  4  code to the 7-seg decoder for the active digit
- an  output  4  anode enables, active-low, bit i = digit i
- dp  output  1  decimal point, active-low
- digit_sel  output  2  index of the current slot
- frame_tick  output  1  one-cycle pulse at the first cycle of each frame

## Operation
- States: IDLE, DEAD, DRIVE. Slot counter cnt counts 0..SLOT_CYCLES-1. Digit index sel counts 0..3 and wraps 3→0.
- Reset (rst_n=0 at a clock edge): state=IDLE, cnt=0, sel=0, snapshot=0. Outputs: an=4'b1111, dp=1, bcd_out=0, digit_sel=0, frame_tick=0.
- IDLE: an=1111, dp=1. When enable=1, go to DEAD with cnt=0 and sel=0. This is a frame start: snapshot←digits, lz flags computed, frame_tick=1.
- DEAD: an=1111, dp=1, bcd_out already equals the new digit's code. cnt increments. When cnt=DEAD_CYCLES-1, go to DRIVE.
- DRIVE: an[sel]=0 unless the digit is blanked; all other bits are 1. dp=~dp_en[sel], and dp is forced to 1 if the digit is blanked. When cnt=SLOT_CYCLES-1, set cnt←0, sel←sel+1 and go to DEAD. When sel wraps 3→0, a new frame starts: take a new snapshot and pulse frame_tick.
- Blanking of digit i (from the snapshot):
  - The code is >9, or
  - blank_lz=1 and i≥1 and digit i and all higher digits are 0.
  - Digit 0 is never blanked for being zero.
- bcd_out = snapshot nibble[sel]. It is forced to 0 when the digit is blanked.
- Snapshot is taken only at frame start. Changes to digits mid-frame are not shown until the next frame. dp_en and blank_lz are also sampled only at frame start.
- enable=0 in any state: the next state is IDLE, cnt=0, sel=0. an=1111 and dp=1 from the next cycle on.
- Reset or enable drop mid-slot aborts the slot immediately. No partial-frame resume.

## Timing
- All outputs are registered. Transitions take effect on the cycle after the controlling edge.
- From enable rising (sampled) to the first anode low: DEAD_CYCLES+1 cycles.
- Each digit is lit for SLOT_CYCLES-DEAD_CYCLES cycles per slot.
- Frame period is 4·SLOT_CYCLES cycles. frame_tick has the same period and is high for 1 cycle.
- At most one bit of an is low in any cycle. an is all-ones on every DEAD cycle, so consecutive digits are never lit back-to-back.
- bcd_out changes only on the first DEAD cycle of a slot. It is stable throughout DRIVE.
- A digit_sel change coincides with the DRIVE→DEAD transition.

## Test plan
- Reset/idle: assert rst_n=0 for 3 cycles with enable=1, then release. During reset an=1111, dp=1, bcd_out=0, frame_tick=0. First anode low occurs exactly DEAD_CYCLES+1 cycles after release.
- Basic scan (SLOT_CYCLES=8, DEAD_CYCLES=2, digits=16'h1234, dp_en=0100, blank_lz=0):
  - Sequence an=1110/bcd 4, 1101/bcd 3, 1011/bcd 2, 0111/bcd 1.
  - Each digit is low for 6 cycles, with 2 all-ones cycles between digits.
  - dp=0 only while an=1011.
  - frame_tick every 32 cycles.
- Leading zeros: digits=16'h0005, blank_lz=1 → only an=1110 ever goes low (bcd 5). With blank_lz=0, all four digits light, with bcd 0,0,0 on digits 1..3. digits=16'h0000 with blank_lz=1 → digit 0 shows 0.
- Invalid/interior zero: digits=16'h30A0, blank_lz=1 → digit 1 (A) is blanked with bcd_out=0. Digits 0 (0) and 2 (0) light because digit 2 is interior to the nonzero digit 3. Digit 3 shows 3.
- Snapshot coherence: change digits from 16'h1234 to 16'h5678 while sel=1 → the rest of the frame still shows 2, 1. The next frame shows 8, 7, 6, 5.
- Enable drop: deassert enable during DRIVE of digit 2 → an=1111 on the next cycle and stays 1111. Re-assert enable → the frame restarts at digit 0 with a frame_tick pulse.
